memory_stage: RTL and testbench

- Pipeline stage 4: consumes execute-stage results and performs data-memory loads and stores over a req/ack interface.
- Hands the writeback stage `mem_result` plus a single-cycle `mem_result_valid` pulse and the sideband controls for that instruction.
- Stalls execute through `mem_ready` while an access is outstanding.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/memory_stage_if.sv | 25 ++
 rtl/memory_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
//   master : memory stage side (drives req/we/addr/wdata/wstrb, samples ack/rdata)
//   slave  : data memory side (samples the request, drives ack/rdata)
// dmem_req is held until dmem_ack; the request fields stay stable while it is held.
interface memory_stage_if #(
  parameter int ADDR_W = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [63:0]       dmem_wdata;
  logic [7:0]        dmem_wstrb;
  logic              dmem_ack;
  logic [63:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage 4. Takes execute results, performs data-memory
// loads/stores over a req/ack bus and hands writeback a one-cycle valid pulse
// with the result and the instruction's sideband controls.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ex_*                instruction offered by execute (accepted on ex_valid && mem_ready)
//   mem_ready           high while idle; low while a memory access is outstanding
//   dmem                data-memory bus (memory_stage_if.master)
//   mem_result(_valid)  result to writeback, valid pulses one cycle per instruction
//   result_is_branch_addr, write_to_rd, rd, should_end_program
//                       registered sideband, aligned with mem_result
//
// Parameters:
//   ACK_TIMEOUT  cycles to wait for dmem_ack before aborting (0 = wait forever)
//   ADDR_W       data-memory address width
//
// Build option: define MEM_MISALIGN_TRAP_EN to turn misaligned loads/stores
// into a 1-cycle end-of-program result instead of an aligned-down access.
module memory_stage #(
  parameter int ACK_TIMEOUT = 0,
  parameter int ADDR_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 mem_ready,
  input  logic [63:0]          ex_result,
  input  logic [63:0]          ex_store_data,
  input  logic [1:0]           ex_mem_op,
  input  logic [1:0]           ex_mem_size,
  input  logic                 ex_load_unsigned,
  input  logic                 ex_result_is_branch_addr,
  input  logic                 ex_write_to_rd,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_should_end_program,
  memory_stage_if.master       dmem,
  output logic [63:0]          mem_result,
  output logic                 mem_result_valid,
  output logic                 result_is_branch_addr,
  output logic                 write_to_rd,
  output logic [4:0]           rd,
  output logic                 should_end_program
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Clears the lane bits below the access size.
  function automatic logic [2:0] lane_align(input logic [2:0] lane, input logic [1:0] size);
    case (size)
      2'd0:    return lane;
      2'd1:    return {lane[2:1], 1'b0};
      2'd2:    return {lane[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [2:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (size)
      2'd0:    return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  state_t      state, state_next;
  logic        is_mem, trap;
  logic [2:0]  eff_lane;
  logic        issue, pass, done_ack, done_timeout, timeout_hit;
  logic [31:0] wait_cnt;

  // Request registers driving the bus
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [63:0]       wdata_p1;
  logic [7:0]        wstrb_p1;

  // Instruction fields kept for completion of an outstanding access
  logic [63:0] result_p1;
  logic [2:0]  lane_p1;
  logic [1:0]  size_p1;
  logic        uns_p1, branch_p1, wrd_p1, end_p1;
  logic [4:0]  rd_p1;

  assign is_mem   = (ex_mem_op == OP_LOAD) || (ex_mem_op == OP_STORE);
  assign eff_lane = lane_align(ex_result[2:0], ex_mem_size);

`ifdef MEM_MISALIGN_TRAP_EN
  // Power-of-two sizes aligned to their size never cross the doubleword,
  // so a lane/size mismatch covers both misalignment cases.
  assign trap = is_mem && (eff_lane != ex_result[2:0]);
`else
  assign trap = 1'b0;
`endif

  assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == 32'(ACK_TIMEOUT - 1));

  assign mem_ready        = (state == IDLE);
  assign dmem.dmem_req    = (state == ACCESS);
  assign dmem.dmem_we     = we_p1;
  assign dmem.dmem_addr   = addr_p1;
  assign dmem.dmem_wdata  = wdata_p1;
  assign dmem.dmem_wstrb  = wstrb_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    pass         = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (is_mem && !trap) begin
            issue      = 1'b1;
            state_next = ACCESS;
          end else begin
            pass = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (dmem.dmem_ack) begin
          done_ack   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          done_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      wait_cnt <= '0;
    else if (issue)                                wait_cnt <= '0;
    else if (state == ACCESS && !dmem.dmem_ack)    wait_cnt <= wait_cnt + 32'd1;
  end

  // ---- stage p1: latch the request on accept ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      wstrb_p1 <= '0;
    end else if (issue) begin
      we_p1    <= (ex_mem_op == OP_STORE);
      addr_p1  <= {ex_result[ADDR_W-1:3], 3'b000};
      wdata_p1 <= ex_store_data << {eff_lane, 3'b000};
      wstrb_p1 <= size_mask(ex_mem_size) << eff_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      result_p1 <= ex_result;
      lane_p1   <= eff_lane;
      size_p1   <= ex_mem_size;
      uns_p1    <= ex_load_unsigned;
      branch_p1 <= ex_result_is_branch_addr;
      wrd_p1    <= ex_write_to_rd && (ex_mem_op != OP_STORE);
      rd_p1     <= ex_rd;
      end_p1    <= ex_should_end_program;
    end
  end

  // ---- stage p2: writeback result and sideband ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_result            <= '0;
      mem_result_valid      <= 1'b0;
      result_is_branch_addr <= 1'b0;
      write_to_rd           <= 1'b0;
      rd                    <= '0;
      should_end_program    <= 1'b0;
    end else begin
      mem_result_valid <= pass || done_ack || done_timeout;
      if (pass) begin
        mem_result            <= ex_result;
        result_is_branch_addr <= ex_result_is_branch_addr;
        write_to_rd           <= ex_write_to_rd && !trap;
        rd                    <= ex_rd;
        should_end_program    <= ex_should_end_program || trap;
      end else if (done_ack) begin
        mem_result            <= we_p1 ? result_p1
                                       : load_extend(dmem.dmem_rdata, lane_p1, size_p1, uns_p1);
        result_is_branch_addr <= branch_p1;
        write_to_rd           <= wrd_p1;
        rd                    <= rd_p1;
        should_end_program    <= end_p1;
      end else if (done_timeout) begin
        mem_result            <= result_p1;
        result_is_branch_addr <= branch_p1;
        write_to_rd           <= 1'b0;
        rd                    <= rd_p1;
        should_end_program    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: one instance with no ack timeout and one
// with ACK_TIMEOUT=4 sharing the execute-side fields.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_valid_to;
  logic [63:0] ex_result, ex_store_data;
  logic [1:0]  ex_mem_op, ex_mem_size;
  logic        ex_load_unsigned, ex_result_is_branch_addr, ex_write_to_rd;
  logic [4:0]  ex_rd;
  logic        ex_should_end_program;

  logic        mem_ready, mem_result_valid, result_is_branch_addr, write_to_rd, should_end_program;
  logic [63:0] mem_result;
  logic [4:0]  rd;

  logic        mem_ready_to, mem_result_valid_to, result_is_branch_addr_to, write_to_rd_to;
  logic        should_end_program_to;
  logic [63:0] mem_result_to;
  logic [4:0]  rd_to;

  memory_stage_if #(.ADDR_W(64)) bus ();
  memory_stage_if #(.ADDR_W(64)) bus_to ();

  memory_stage #(.ACK_TIMEOUT(0), .ADDR_W(64)) u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_ready(mem_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_mem_size(ex_mem_size), .ex_load_unsigned(ex_load_unsigned),
    .ex_result_is_branch_addr(ex_result_is_branch_addr), .ex_write_to_rd(ex_write_to_rd),
    .ex_rd(ex_rd), .ex_should_end_program(ex_should_end_program), .dmem(bus.master),
    .mem_result(mem_result), .mem_result_valid(mem_result_valid),
    .result_is_branch_addr(result_is_branch_addr), .write_to_rd(write_to_rd),
    .rd(rd), .should_end_program(should_end_program)
  );

  memory_stage #(.ACK_TIMEOUT(4), .ADDR_W(64)) u_dut_to (
    .clk(clk), .rst(rst), .ex_valid(ex_valid_to), .mem_ready(mem_ready_to),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_mem_size(ex_mem_size), .ex_load_unsigned(ex_load_unsigned),
    .ex_result_is_branch_addr(ex_result_is_branch_addr), .ex_write_to_rd(ex_write_to_rd),
    .ex_rd(ex_rd), .ex_should_end_program(ex_should_end_program), .dmem(bus_to.master),
    .mem_result(mem_result_to), .mem_result_valid(mem_result_valid_to),
    .result_is_branch_addr(result_is_branch_addr_to), .write_to_rd(write_to_rd_to),
    .rd(rd_to), .should_end_program(should_end_program_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s_req, s_we;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_wstrb;
  int          low;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [1:0] op, input logic [1:0] size,
                        input logic uns, input logic [63:0] res, input logic [63:0] sdata,
                        input logic wrd, input logic [4:0] rdn, input logic fin, input logic br);
    ex_valid                 = v;
    ex_mem_op                = op;
    ex_mem_size              = size;
    ex_load_unsigned         = uns;
    ex_result                = res;
    ex_store_data            = sdata;
    ex_write_to_rd           = wrd;
    ex_rd                    = rdn;
    ex_should_end_program    = fin;
    ex_result_is_branch_addr = br;
  endtask

  // Called at the negedge where the access is being offered. Captures the bus
  // one cycle later, then answers after 'waits' request cycles without ack.
  // Returns at the negedge where the result pulse is expected.
  task automatic run_access(input int waits, input logic [63:0] rdata, output int lowcnt);
    @(negedge clk);
    ex_valid = 1'b0;
    s_req   = bus.dmem_req;
    s_we    = bus.dmem_we;
    s_addr  = bus.dmem_addr;
    s_wdata = bus.dmem_wdata;
    s_wstrb = bus.dmem_wstrb;
    lowcnt  = 0;
    for (int i = 0; i < waits; i++) begin
      if (!mem_ready) lowcnt++;
      @(negedge clk);
    end
    if (!mem_ready) lowcnt++;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdata;
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
  endtask

  initial begin
    int pulses, reqs;
    logic seen, end_s, wrd_s;
    logic [63:0] res_s;

    rst = 1'b1;
    set_ex(1'b0, 2'd0, 2'd0, 1'b0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_valid_to       = 1'b0;
    bus.dmem_ack      = 1'b0;
    bus.dmem_rdata    = 64'd0;
    bus_to.dmem_ack   = 1'b0;
    bus_to.dmem_rdata = 64'd0;
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", mem_ready, 1'b1);
    check("rst_req", bus.dmem_req, 1'b0);
    check("rst_valid", mem_result_valid, 1'b0);
    check("rst_result", mem_result, 64'd0);
    check("rst_wstrb", bus.dmem_wstrb, 8'h00);
    check("rst_rd", rd, 5'd0);
    rst = 1'b1;

    // ALU op passes through in one cycle
    @(negedge clk);
    set_ex(1'b1, 2'd0, 2'd3, 1'b0, 64'h1234, 64'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("alu_valid", mem_result_valid, 1'b1);
    check("alu_result", mem_result, 64'h1234);
    check("alu_rd", rd, 5'd5);
    check("alu_wrd", write_to_rd, 1'b1);
    check("alu_ready", mem_ready, 1'b1);
    check("alu_req", bus.dmem_req, 1'b0);

    // Back-to-back accepts
    set_ex(1'b1, 2'd0, 2'd0, 1'b0, 64'h11, 64'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b1_valid", mem_result_valid, 1'b1);
    check("b2b1_result", mem_result, 64'h11);
    set_ex(1'b1, 2'd0, 2'd0, 1'b0, 64'h22, 64'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b2_valid", mem_result_valid, 1'b1);
    check("b2b2_result", mem_result, 64'h22);
    check("b2b2_ready", mem_ready, 1'b1);
    ex_valid = 1'b0;
    @(negedge clk);
    check("hold_valid", mem_result_valid, 1'b0);
    check("hold_result", mem_result, 64'h22);
    check("hold_rd", rd, 5'd7);

    // Reserved op is a non-memory op; sideband forwarded
    set_ex(1'b1, 2'd3, 2'd0, 1'b0, 64'hDEAD, 64'd0, 1'b1, 5'd9, 1'b1, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("rsv_valid", mem_result_valid, 1'b1);
    check("rsv_req", bus.dmem_req, 1'b0);
    check("rsv_result", mem_result, 64'hDEAD);
    check("rsv_branch", result_is_branch_addr, 1'b1);
    check("rsv_end", should_end_program, 1'b1);
    @(negedge clk);

    // LB at 0x1003, three request cycles without ack then ack
    set_ex(1'b1, 2'd1, 2'd0, 1'b0, 64'h1003, 64'd0, 1'b1, 5'd10, 1'b0, 1'b0);
    run_access(3, 64'h0000_0000_8000_0000, low);
    check("lb_req", s_req, 1'b1);
    check("lb_addr", s_addr, 64'h1000);
    check("lb_we", s_we, 1'b0);
    check("lb_ready_low", low, 4);
    check("lb_valid", mem_result_valid, 1'b1);
    check("lb_result", mem_result, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_rd", rd, 5'd10);
    check("lb_end", should_end_program, 1'b0);
    check("lb_branch", result_is_branch_addr, 1'b0);

    // LBU, same stimulus
    set_ex(1'b1, 2'd1, 2'd0, 1'b1, 64'h1003, 64'd0, 1'b1, 5'd11, 1'b0, 1'b0);
    run_access(3, 64'h0000_0000_8000_0000, low);
    check("lbu_valid", mem_result_valid, 1'b1);
    check("lbu_result", mem_result, 64'h80);

    // SH at 0x2006, ack on the first request cycle (2-cycle latency)
    set_ex(1'b1, 2'd2, 2'd1, 1'b0, 64'h2006, 64'hABCD, 1'b1, 5'd12, 1'b0, 1'b0);
    run_access(0, 64'hFFFF_FFFF_FFFF_FFFF, low);
    check("sh_we", s_we, 1'b1);
    check("sh_addr", s_addr, 64'h2000);
    check("sh_wstrb", s_wstrb, 8'hC0);
    check("sh_wdata", s_wdata, 64'hABCD_0000_0000_0000);
    check("sh_ready_low", low, 1);
    check("sh_valid", mem_result_valid, 1'b1);
    check("sh_wrd", write_to_rd, 1'b0);
    check("sh_result", mem_result, 64'h2006);

    // LWU at 0x4004
    set_ex(1'b1, 2'd1, 2'd2, 1'b1, 64'h4004, 64'd0, 1'b1, 5'd13, 1'b0, 1'b0);
    run_access(1, 64'h89AB_CDEF_0123_4567, low);
    check("lwu_wstrb", s_wstrb, 8'hF0);
    check("lwu_result", mem_result, 64'h0000_0000_89AB_CDEF);
    check("lwu_wrd", write_to_rd, 1'b1);

    // LD at 0x4008 with the unsigned flag set (ignored for dword)
    set_ex(1'b1, 2'd1, 2'd3, 1'b1, 64'h4008, 64'd0, 1'b1, 5'd14, 1'b0, 1'b0);
    run_access(0, 64'hFEDC_BA98_7654_3210, low);
    check("ld_addr", s_addr, 64'h4008);
    check("ld_wstrb", s_wstrb, 8'hFF);
    check("ld_result", mem_result, 64'hFEDC_BA98_7654_3210);

    // Misaligned LW at 0x3002
`ifdef MEM_MISALIGN_TRAP_EN
    set_ex(1'b1, 2'd1, 2'd2, 1'b0, 64'h3002, 64'd0, 1'b1, 5'd15, 1'b0, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("mis_req", bus.dmem_req, 1'b0);
    check("mis_ready", mem_ready, 1'b1);
    check("mis_valid", mem_result_valid, 1'b1);
    check("mis_end", should_end_program, 1'b1);
    check("mis_wrd", write_to_rd, 1'b0);
    check("mis_result", mem_result, 64'h3002);
`else
    set_ex(1'b1, 2'd1, 2'd2, 1'b0, 64'h3002, 64'd0, 1'b1, 5'd15, 1'b0, 1'b0);
    run_access(0, 64'h1122_3344_8877_6655, low);
    check("mis_req", s_req, 1'b1);
    check("mis_addr", s_addr, 64'h3000);
    check("mis_wstrb", s_wstrb, 8'h0F);
    check("mis_valid", mem_result_valid, 1'b1);
    check("mis_result", mem_result, 64'hFFFF_FFFF_8877_6655);
    check("mis_wrd", write_to_rd, 1'b1);
`endif
    @(negedge clk);

    // Reset while an access is outstanding
    set_ex(1'b1, 2'd1, 2'd3, 1'b0, 64'h5000, 64'd0, 1'b1, 5'd16, 1'b0, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("mid_req_before", bus.dmem_req, 1'b1);
    check("mid_ready_before", mem_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_req_reset", bus.dmem_req, 1'b0);
    check("mid_ready_reset", mem_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    // An ack arriving while idle must be ignored as well.
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'h1;
    pulses = 0;
    reqs   = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_result_valid) pulses++;
      if (bus.dmem_req) reqs++;
    end
    bus.dmem_ack = 1'b0;
    check("mid_no_pulse", pulses, 0);
    check("mid_no_req", reqs, 0);
    check("mid_ready_after", mem_ready, 1'b1);

    // Ack timeout on the ACK_TIMEOUT=4 instance
    set_ex(1'b0, 2'd1, 2'd3, 1'b0, 64'h6000, 64'd0, 1'b1, 5'd3, 1'b0, 1'b0);
    ex_valid_to = 1'b1;
    reqs  = 0;
    seen  = 1'b0;
    end_s = 1'b0;
    wrd_s = 1'b1;
    res_s = 64'd0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      ex_valid_to = 1'b0;
      if (bus_to.dmem_req) reqs++;
      if (mem_result_valid_to) begin
        seen  = 1'b1;
        end_s = should_end_program_to;
        wrd_s = write_to_rd_to;
        res_s = mem_result_to;
      end
    end
    check("to_valid_seen", seen, 1'b1);
    check("to_req_cycles", reqs, 4);
    check("to_end", end_s, 1'b1);
    check("to_wrd", wrd_s, 1'b0);
    check("to_result", res_s, 64'h6000);
    check("to_ready", mem_ready_to, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
